// File: rtl/xtal_osc_supervisor_if.sv
// -----------------------------------------------------------------------------
// xtal_osc_supervisor_if
//
// Purpose: groups the per-channel oscillator control/status signals exchanged
// between the housekeeping side and the crystal oscillator supervisor.
//
// Signals (all NUM_OSC wide except irq):
//   en        housekeeping -> supervisor  channel enable request
//   osc_clk   oscillator   -> supervisor  raw oscillator clocks (async to clk)
//   clr_lost  housekeeping -> supervisor  write-1-to-clear for lost
//   osc_en    supervisor   -> oscillator  oscillator enable pins
//   osc_good  supervisor   -> housekeeping channel locked and in range
//   osc_fail  supervisor   -> housekeeping channel timed out
//   lost      supervisor   -> housekeeping sticky: channel dropped out of GOOD
//   irq       supervisor   -> housekeeping OR of lost
//
// Modports: master = housekeeping/oscillator side, slave = supervisor.
// -----------------------------------------------------------------------------
interface xtal_osc_supervisor_if #(
    parameter int NUM_OSC = 2
);
    logic [NUM_OSC-1:0] en;
    logic [NUM_OSC-1:0] osc_clk;
    logic [NUM_OSC-1:0] clr_lost;
    logic [NUM_OSC-1:0] osc_en;
    logic [NUM_OSC-1:0] osc_good;
    logic [NUM_OSC-1:0] osc_fail;
    logic [NUM_OSC-1:0] lost;
    logic               irq;

    modport master (
        output en, osc_clk, clr_lost,
        input  osc_en, osc_good, osc_fail, lost, irq
    );

    modport slave (
        input  en, osc_clk, clr_lost,
        output osc_en, osc_good, osc_fail, lost, irq
    );
endinterface

// File: rtl/xtal_osc_supervisor.sv
// -----------------------------------------------------------------------------
// xtal_osc_supervisor
//
// Purpose: start-up sequencer and frequency monitor for NUM_OSC crystal
// oscillator channels, clocked by the always-on core clock. Each channel is
// enabled, allowed STARTUP_WINDOWS windows to settle, then its synchronised
// rising edges are counted per WIN_CYCLES window. GOOD_WINDOWS consecutive
// in-range windows declare the channel good; TIMEOUT_WINDOWS lock windows
// without success declare it failed (and power it down). Dropping out of GOOD
// sets a sticky lost flag, which drives irq.
//
// Ports:
//   clk         core clock (oscillator frequency must be below clk/2)
//   resetn      asynchronous active-low reset
//   bus         xtal_osc_supervisor_if.slave (en, osc_clk, clr_lost in;
//               osc_en, osc_good, osc_fail, lost, irq out)
//
// Optional feature, enabled by defining XTAL_OSC_SUPERVISOR_COUNT_OUT_EN:
//   cnt_sel     selects the channel shown on last_count
//   last_count  edge count captured at the most recent window end for cnt_sel
// -----------------------------------------------------------------------------
module xtal_osc_supervisor #(
    parameter int NUM_OSC         = 2,
    parameter int WIN_CYCLES      = 256,
    parameter int MIN_EDGES       = 56,
    parameter int MAX_EDGES       = 72,
    parameter int STARTUP_WINDOWS = 4,
    parameter int GOOD_WINDOWS    = 3,
    parameter int TIMEOUT_WINDOWS = 16,
    localparam int CW = $clog2(WIN_CYCLES + 1),
    localparam int SW = (NUM_OSC > 1) ? $clog2(NUM_OSC) : 1
) (
    input  logic                clk,
    input  logic                resetn,
`ifdef XTAL_OSC_SUPERVISOR_COUNT_OUT_EN
    input  logic [SW-1:0]       cnt_sel,
    output logic [CW-1:0]       last_count,
`endif
    xtal_osc_supervisor_if.slave bus
);

    localparam int TW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam int WW = $clog2(STARTUP_WINDOWS + 1);
    localparam int GW = $clog2(GOOD_WINDOWS + 1);
    localparam int OW = $clog2(TIMEOUT_WINDOWS + 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [2:0] {
        ST_OFF,
        ST_WAIT,
        ST_LOCKING,
        ST_GOOD,
        ST_FAIL
    } state_e;

    // ---------------------------------------------------------------- edges
    logic [NUM_OSC-1:0] sync1_q, sync2_q, sync3_q;
    logic [NUM_OSC-1:0] rise;

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= bus.osc_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise = sync2_q & ~sync3_q;

    // --------------------------------------------------------- window timer
    logic [TW-1:0] win_cnt_q;
    logic          win_end;

    assign win_end = (win_cnt_q == TW'(WIN_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_cnt_q <= '0;
        end else if (win_end) begin
            win_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------- edge counters
    logic [CW-1:0] edge_cnt_q [NUM_OSC];

    // NOTE: these per-channel arrays are plain flops rather than RAM, so they
    // are reset like any other register; every count must start from zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_OSC; i++) edge_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OSC; i++) begin
                if (win_end) begin
                    // An edge landing on the window boundary belongs to the
                    // next window, so it seeds the reloaded count.
                    edge_cnt_q[i] <= rise[i] ? CW'(1) : '0;
                end else if (rise[i] && (edge_cnt_q[i] != CNT_MAX)) begin
                    edge_cnt_q[i] <= edge_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------- per-channel FSMs
    state_e             state_q [NUM_OSC];
    logic [WW-1:0]      wcnt_q  [NUM_OSC];
    logic [GW-1:0]      gcnt_q  [NUM_OSC];
    logic [OW-1:0]      tcnt_q  [NUM_OSC];
    logic [OW-1:0]      tcnt_inc [NUM_OSC];
    logic [NUM_OSC-1:0] in_range;
    logic [NUM_OSC-1:0] lost_set;
    logic [NUM_OSC-1:0] lost_d;
    logic [NUM_OSC-1:0] osc_en_q, osc_good_q, osc_fail_q, lost_q;
    logic               irq_q;

    // NOTE: every always_comb output gets a default before any conditional
    // logic so no path can leave it unassigned and infer a latch.
    always_comb begin
        in_range = '0;
        lost_set = '0;
        for (int i = 0; i < NUM_OSC; i++) begin
            in_range[i] = (edge_cnt_q[i] >= CW'(MIN_EDGES)) &&
                          (edge_cnt_q[i] <= CW'(MAX_EDGES));
            // tcnt saturates so a channel that is in range on its last
            // permitted window still times out on the next bad one.
            tcnt_inc[i] = (tcnt_q[i] == OW'(TIMEOUT_WINDOWS)) ? tcnt_q[i]
                                                              : tcnt_q[i] + 1'b1;
            lost_set[i] = bus.en[i] && (state_q[i] == ST_GOOD) &&
                          win_end && !in_range[i];
        end
    end

    // Set wins over a simultaneous clear.
    assign lost_d = lost_set | (lost_q & ~bus.clr_lost);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_OSC; i++) begin
                state_q[i] <= ST_OFF;
                wcnt_q[i]  <= '0;
                gcnt_q[i]  <= '0;
                tcnt_q[i]  <= '0;
            end
            osc_en_q   <= '0;
            osc_good_q <= '0;
            osc_fail_q <= '0;
            lost_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            lost_q <= lost_d;
            irq_q  <= |lost_d;
            for (int i = 0; i < NUM_OSC; i++) begin
                if (!bus.en[i]) begin
                    state_q[i]    <= ST_OFF;
                    wcnt_q[i]     <= '0;
                    gcnt_q[i]     <= '0;
                    tcnt_q[i]     <= '0;
                    osc_en_q[i]   <= 1'b0;
                    osc_good_q[i] <= 1'b0;
                    osc_fail_q[i] <= 1'b0;
                end else begin
                    unique case (state_q[i])
                        ST_OFF: begin
                            state_q[i]  <= ST_WAIT;
                            wcnt_q[i]   <= '0;
                            osc_en_q[i] <= 1'b1;
                        end
                        ST_WAIT: begin
                            if (win_end) begin
                                wcnt_q[i] <= wcnt_q[i] + 1'b1;
                                if (wcnt_q[i] + 1'b1 == WW'(STARTUP_WINDOWS)) begin
                                    state_q[i] <= ST_LOCKING;
                                    gcnt_q[i]  <= '0;
                                    tcnt_q[i]  <= '0;
                                end
                            end
                        end
                        ST_LOCKING: begin
                            if (win_end) begin
                                tcnt_q[i] <= tcnt_inc[i];
                                if (in_range[i]) begin
                                    gcnt_q[i] <= gcnt_q[i] + 1'b1;
                                    if (gcnt_q[i] + 1'b1 == GW'(GOOD_WINDOWS)) begin
                                        state_q[i]    <= ST_GOOD;
                                        osc_good_q[i] <= 1'b1;
                                    end
                                end else begin
                                    gcnt_q[i] <= '0;
                                    if (tcnt_inc[i] == OW'(TIMEOUT_WINDOWS)) begin
                                        state_q[i]    <= ST_FAIL;
                                        osc_en_q[i]   <= 1'b0;
                                        osc_fail_q[i] <= 1'b1;
                                    end
                                end
                            end
                        end
                        ST_GOOD: begin
                            if (win_end && !in_range[i]) begin
                                state_q[i]    <= ST_LOCKING;
                                gcnt_q[i]     <= '0;
                                tcnt_q[i]     <= '0;
                                osc_good_q[i] <= 1'b0;
                            end
                        end
                        ST_FAIL: begin
                            // Parked with the oscillator off until en drops.
                        end
                        default: begin
                            state_q[i]    <= ST_OFF;
                            osc_en_q[i]   <= 1'b0;
                            osc_good_q[i] <= 1'b0;
                            osc_fail_q[i] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.osc_en   = osc_en_q;
    assign bus.osc_good = osc_good_q;
    assign bus.osc_fail = osc_fail_q;
    assign bus.lost     = lost_q;
    assign bus.irq      = irq_q;

`ifdef XTAL_OSC_SUPERVISOR_COUNT_OUT_EN
    // ---------------------------------------------------- count capture
    logic [CW-1:0] cap_q [NUM_OSC];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_OSC; i++) cap_q[i] <= '0;
        end else if (win_end) begin
            for (int i = 0; i < NUM_OSC; i++) cap_q[i] <= edge_cnt_q[i];
        end
    end

    assign last_count = (int'(cnt_sel) < NUM_OSC) ? cap_q[cnt_sel] : '0;
`endif

endmodule

// File: tb/tb_xtal_osc_supervisor.sv
// -----------------------------------------------------------------------------
// tb_xtal_osc_supervisor
//
// Purpose: directed self-checking bench for xtal_osc_supervisor with default
// parameters. tcyc counts clk rising edges since reset release, which lines up
// with the DUT window timer: the k-th window end takes effect at tcyc = 256*k.
// The oscillator model on channel 0 is either free-running with a period of
// `per` clk cycles, or emits exactly `nmax` pulses per window (spaced `per`
// cycles, starting at window offset 8), or is stuck low (per = 0).
// -----------------------------------------------------------------------------
module tb_xtal_osc_supervisor;

    logic clk;
    logic resetn;
    int   tcyc;
    int   per;
    int   nmax;
    logic osc0;
    logic ever_good;
    int   total;
    int   bad;

    xtal_osc_supervisor_if #(.NUM_OSC(2)) bus ();

`ifdef XTAL_OSC_SUPERVISOR_COUNT_OUT_EN
    logic [0:0] cnt_sel;
    logic [8:0] last_count;
    assign cnt_sel = 1'b0;

    xtal_osc_supervisor dut (
        .clk        (clk),
        .resetn     (resetn),
        .cnt_sel    (cnt_sel),
        .last_count (last_count),
        .bus        (bus)
    );
`else
    xtal_osc_supervisor dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) tcyc <= 0;
        else         tcyc <= tcyc + 1;
    end

    // Oscillator model, updated away from the sampling edge.
    always @(negedge clk) begin
        int ph;
        ph = tcyc % 256;
        if (per == 0)
            osc0 = 1'b0;
        else if (nmax == 0)
            osc0 = ((tcyc % per) == 0);
        else
            osc0 = (ph >= 8) && (ph < 8 + nmax * per) && (((ph - 8) % per) == 0);
        bus.osc_clk = {1'b0, osc0};
    end

    always @(negedge clk) begin
        if (bus.osc_good[0] === 1'b1) ever_good = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to tcyc == t and sample 1 time unit after that edge.
    task automatic wait_to(input int t);
        while (tcyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        bus.en       = '0;
        bus.clr_lost = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn    = 1'b1;
        ever_good = 1'b0;
    endtask

    task automatic fail_case(input string tag, input int p, input int n);
        per  = p;
        nmax = n;
        do_reset();
        bus.en = 2'b01;
        wait_to(5119);
        check({tag, "_fail_pre"}, bus.osc_fail, 2'b00);
        wait_to(5120);
        check({tag, "_fail"}, bus.osc_fail, 2'b01);
        check({tag, "_osc_en_off"}, bus.osc_en, 2'b00);
        check({tag, "_never_good"}, ever_good, 1'b0);
    endtask

    task automatic good_case(input string tag, input int p, input int n);
        per  = p;
        nmax = n;
        do_reset();
        bus.en = 2'b01;
        wait_to(1791);
        check({tag, "_good_pre"}, bus.osc_good, 2'b00);
        wait_to(1792);
        check({tag, "_good"}, bus.osc_good, 2'b01);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        per          = 4;
        nmax         = 0;
        ever_good    = 1'b0;
        resetn       = 1'b0;
        bus.en       = '0;
        bus.clr_lost = '0;

        // Start-up at clk/4 (64 edges per window).
        do_reset();
        check("rst_osc_en",   bus.osc_en,   2'b00);
        check("rst_osc_good", bus.osc_good, 2'b00);
        check("rst_osc_fail", bus.osc_fail, 2'b00);
        check("rst_lost",     bus.lost,     2'b00);
        check("rst_irq",      bus.irq,      1'b0);
        bus.en = 2'b01;
        wait_to(1);
        check("start_osc_en", bus.osc_en, 2'b01);
        wait_to(1791);
        check("start_good_pre", bus.osc_good, 2'b00);
        wait_to(1792);
        check("start_good", bus.osc_good, 2'b01);
        check("start_osc_en_on", bus.osc_en, 2'b01);
        check("start_fail", bus.osc_fail, 2'b00);

        // Oscillator stops while GOOD.
        per = 0;
        wait_to(2047);
        check("loss_good_pre", bus.osc_good, 2'b01);
        check("loss_lost_pre", bus.lost, 2'b00);
        wait_to(2048);
        check("loss_good", bus.osc_good, 2'b00);
        check("loss_lost", bus.lost, 2'b01);
        check("loss_irq", bus.irq, 1'b1);
        bus.clr_lost = 2'b01;
        wait_to(2049);
        bus.clr_lost = 2'b00;
        check("clr_lost", bus.lost, 2'b00);
        check("clr_irq", bus.irq, 1'b0);

        // Relock, then lose again with clr_lost asserted on the same edge.
        per = 4;
        wait_to(2815);
        check("relock_good_pre", bus.osc_good, 2'b00);
        wait_to(2816);
        check("relock_good", bus.osc_good, 2'b01);
        per = 0;
        wait_to(3071);
        check("simul_lost_pre", bus.lost, 2'b00);
        bus.clr_lost = 2'b01;
        wait_to(3072);
        bus.clr_lost = 2'b00;
        check("simul_lost", bus.lost, 2'b01);
        check("simul_irq", bus.irq, 1'b1);
        check("simul_good", bus.osc_good, 2'b00);

        // Stuck low: timeout, then held until en drops.
        fail_case("stuck", 0, 0);
        wait_to(5400);
        check("stuck_fail_held", bus.osc_fail, 2'b01);
        bus.en = 2'b00;
        wait_to(5401);
        check("stuck_fail_clr", bus.osc_fail, 2'b00);
        check("stuck_osc_en_clr", bus.osc_en, 2'b00);

        // Out-of-range frequencies and range boundaries.
        fail_case("clk_div2", 2, 0);
        fail_case("clk_div5", 5, 0);
        fail_case("edges55", 4, 55);
        fail_case("edges73", 3, 73);
        good_case("edges56", 4, 56);
        good_case("edges72", 3, 72);

        // en dropped during LOCKING, then full restart.
        per  = 4;
        nmax = 0;
        do_reset();
        bus.en = 2'b01;
        wait_to(1100);
        bus.en = 2'b00;
        wait_to(1101);
        check("drop_osc_en", bus.osc_en, 2'b00);
        check("drop_good", bus.osc_good, 2'b00);
        wait_to(1200);
        bus.en = 2'b01;
        wait_to(1201);
        check("reen_osc_en", bus.osc_en, 2'b01);
        wait_to(2815);
        check("reen_good_pre", bus.osc_good, 2'b00);
        wait_to(2816);
        check("reen_good", bus.osc_good, 2'b01);

        // Asynchronous reset in LOCKING.
        do_reset();
        bus.en = 2'b01;
        wait_to(1300);
        check("arst_osc_en_pre", bus.osc_en, 2'b01);
        resetn = 1'b0;
        #1;
        check("arst_outputs",
              {bus.osc_en, bus.osc_good, bus.osc_fail, bus.lost, bus.irq}, 9'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        wait_to(1);
        check("arst_restart_osc_en", bus.osc_en, 2'b01);
        wait_to(1791);
        check("arst_good_pre", bus.osc_good, 2'b00);
        wait_to(1792);
        check("arst_good", bus.osc_good, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
